csa_addsub_pipe: RTL and testbench
==================================

# csa_addsub_pipe

- Parametrised, pipelined square-root carry-select adder/subtractor with valid/ready handshakes.
- Successor to the fixed 9-bit combinational carry-select unit; widens it to any operand width and splits the carry chain across register stages.
- Sits in the MACC datapath after the Radix-4 Booth partial-product reduction, feeding the accumulator.
- Cin keeps its meaning: 0 = add, 1 = subtract.

## Interface
Parameters:
- W, 9: signed operand width (legal 4..32).
- STAGES, 2: pipeline register stages (legal 1..3); this is also the latency.

Ports:
- clk  in  1  sole clock, rising-edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts a beat this cycle.
- A  in  W  signed operand.
- B  in  W  signed operand.
- Cin  in  1  mode: 0 gives A+B, 1 gives A−B.
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts the result.
- Out  out  W+1  signed result.
- ovf  out  1  result does not fit in W-bit signed.

## Operation
Arithmetic:
- A and B are sign-extended to W+1 bits.
- Subtract computes A + ~B + 1: the carry-in of block 0 is Cin.
- The full W+1-bit result is exact and never wraps.
- ovf = (Out[W] != Out[W-1]), computed on the unsaturated sum.

Carry-select structure:
- The W+1 bits are partitioned LSB-first into blocks of size 2, 3, 4, 5, …; the last block is truncated to fit (W=9 gives 2,3,4,1).
- Block 0 is a plain ripple-sum adder.
- Every other block computes its sum for carry-in 0 and for carry-in 1 in parallel, then muxes on the incoming block carry.

Pipelining:
- Blocks are assigned to stages in order, ceil(nblocks/STAGES) blocks per stage.
- At each stage boundary, register: the finished low sum bits, the inter-block carry, and the unprocessed upper operand bits plus mode.
- No combinational path from A/B to Out.

Handshake (global-stall pipeline):
- en = !out_valid || out_ready.
- in_ready = en && !rst.
- On en, every stage advances and its valid bit loads from the stage below. Stage 0's valid loads in_valid && in_ready.
- Bubbles are not collapsed while stalled.
- out_valid is the last stage's valid bit; Out/ovf come from the last stage's registers.
- Output hold: while out_valid && !out_ready, Out, ovf and out_valid are held stable and in_ready is 0.
- Simultaneous accept and emit: with a full pipe, out_ready=1 and in_valid=1, one beat leaves and one enters in the same cycle. Throughput is 1 beat/cycle.
- Beats emerge strictly in acceptance order; none are lost or duplicated.

## Timing
Reset:
- Applies at the clk edge where rst=1.
- Clears all stage valid bits, Out=0, ovf=0, out_valid=0.
- in_ready=0 while rst is high.
- Reset mid-operation discards every in-flight beat; no stale beat appears after rst falls.

Latency:
- A beat accepted at edge k is presented with out_valid=1 after edge k+STAGES, provided no stall occurred.
- Each stalled cycle adds exactly one cycle of latency.

Input rules:
- A, B and Cin are sampled only at an accepting edge.
- Values on A, B and Cin while in_valid=0 are ignored.

## Configuration
CSA_SAT_EN controls output saturation.
- Defined:
  - Out is saturated to the W-bit signed range and sign-extended to W+1 bits, i.e. clamped to [−2^(W−1), 2^(W−1)−1].
  - Saturation is applied in the last stage; it does not change latency.
  - ovf is still raised whenever saturation occurred.
- Undefined:
  - Out carries the exact W+1-bit result.
  - ovf is informational only.

## Test plan
All scenarios use W=9, STAGES=2 unless noted.
- Add: A=51, B=29, Cin=0 → Out=80 (0001010000), ovf=0, out_valid 2 cycles after accept.
- Subtract: A=−26, B=6, Cin=1 → Out=−32 (1111100000). A=37, B=18, Cin=1 → Out=19. Both issued back-to-back and emerge on consecutive cycles.
- Overflow boundary: A=−256, B=255, Cin=1.
  - Without CSA_SAT_EN: Out=−511 (1000000001), ovf=1.
  - With CSA_SAT_EN: Out=−256, ovf=1.
  - Also A=−77, B=−51, Cin=0 → Out=−128, ovf=0.
- Backpressure:
  - Stimulus: stream 4 beats with in_valid held high; drop out_ready for 3 cycles after the first out_valid.
  - Required: Out held stable, in_ready=0 during the stall, all 4 results delivered in order, none repeated.
- Reset mid-stream:
  - Stimulus: assert rst for 1 cycle with 2 beats in flight.
  - Required: next cycle out_valid=0, Out=0, ovf=0; after release only newly accepted beats appear.
- Random regression: W=16, STAGES=3; 1000 random operands/modes with random in_valid and out_ready, checked against a behavioural A±B model (both macro settings).

Source files
------------

// File: rtl/csa_addsub_pipe.sv
// csa_addsub_pipe: pipelined square-root carry-select adder/subtractor with a global-stall valid/ready pipe.
// Build option: define CSA_SAT_EN to clamp Out to the W-bit signed range.
module csa_addsub_pipe #(
  parameter int W      = 9,
  parameter int STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] A,
  input  logic signed [W-1:0] B,
  input  logic                Cin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W:0]   Out,
  output logic                ovf
);
  localparam int N = W + 1;

  // Blocks grow 2,3,4,... so block b starts at b*(b+3)/2; the last one is clipped at N.
  function automatic int blk_start(input int b);
    int s;
    s = (b * (b + 3)) / 2;
    return (s > N) ? N : s;
  endfunction

  function automatic int count_blocks();
    int b;
    b = 0;
    while (blk_start(b) < N) b++;
    return b;
  endfunction

  localparam int NBLK = count_blocks();
  localparam int BPS  = (NBLK + STAGES - 1) / STAGES;

  function automatic logic signed [N-1:0] sat_fn(input logic signed [N-1:0] x);
    logic signed [N-1:0] r;
    r = x;
`ifdef CSA_SAT_EN
    if (x[W] != x[W-1]) r = x[W] ? {2'b11, {(W-1){1'b0}}} : {2'b00, {(W-1){1'b1}}};
`endif
    return r;
  endfunction

  function automatic logic ovf_fn(input logic signed [N-1:0] x);
    return x[W] != x[W-1];
  endfunction

  logic [STAGES:0]     vld_q;
  logic                en;
  logic signed [N-1:0] ia_q, ib_q;
  logic                im_q;
  logic signed [N-1:0] pa_q [STAGES];
  logic signed [N-1:0] pb_q [STAGES];
  logic signed [N-1:0] ps_q [STAGES];
  logic                pm_q [STAGES];
  logic                pc_q [STAGES];
  logic signed [N-1:0] out_q;
  logic                ovf_q;

  logic signed [N-1:0] a_st  [STAGES];
  logic signed [N-1:0] b_st  [STAGES];
  logic signed [N-1:0] s_st  [STAGES];
  logic                m_st  [STAGES];
  logic                c_st  [STAGES];
  logic signed [N-1:0] sum_d [STAGES];
  logic                cy_d  [STAGES];

  assign en        = !vld_q[STAGES] || out_ready;
  assign in_ready  = en && !rst;
  assign out_valid = vld_q[STAGES];
  assign Out       = out_q;
  assign ovf       = ovf_q;

  always_comb begin
    a_st[0] = ia_q;
    b_st[0] = ib_q;
    m_st[0] = im_q;
    c_st[0] = im_q;
    s_st[0] = '0;
    for (int j = 1; j < STAGES; j++) begin
      a_st[j] = pa_q[j-1];
      b_st[j] = pb_q[j-1];
      m_st[j] = pm_q[j-1];
      c_st[j] = pc_q[j-1];
      s_st[j] = ps_q[j-1];
    end
  end

  // Compute stage j: finishes blocks [j*BPS, (j+1)*BPS) on top of the partial sum from stage j-1.
  always_comb begin
    logic [N-1:0] bx, s0v, s1v, acc;
    logic         c, c0, c1;
    int           lo, hi;
    bx  = '0;
    s0v = '0;
    s1v = '0;
    acc = '0;
    c   = 1'b0;
    c0  = 1'b0;
    c1  = 1'b0;
    lo  = 0;
    hi  = 0;
    sum_d = '{default: '0};
    cy_d  = '{default: 1'b0};
    for (int j = 0; j < STAGES; j++) begin
      acc = s_st[j];
      c   = c_st[j];
      bx  = m_st[j] ? ~b_st[j] : b_st[j];
      for (int k = j * BPS; (k < (j + 1) * BPS) && (k < NBLK); k++) begin
        lo = blk_start(k);
        hi = blk_start(k + 1);
        if (k == 0) begin
          for (int i = lo; i < hi; i++) begin
            acc[i] = a_st[j][i] ^ bx[i] ^ c;
            c      = (a_st[j][i] & bx[i]) | (c & (a_st[j][i] ^ bx[i]));
          end
        end else begin
          c0 = 1'b0;
          c1 = 1'b1;
          for (int i = lo; i < hi; i++) begin
            s0v[i] = a_st[j][i] ^ bx[i] ^ c0;
            c0     = (a_st[j][i] & bx[i]) | (c0 & (a_st[j][i] ^ bx[i]));
            s1v[i] = a_st[j][i] ^ bx[i] ^ c1;
            c1     = (a_st[j][i] & bx[i]) | (c1 & (a_st[j][i] ^ bx[i]));
          end
          for (int i = lo; i < hi; i++) acc[i] = c ? s1v[i] : s0v[i];
          c = c ? c1 : c0;
        end
      end
      sum_d[j] = acc;
      cy_d[j]  = c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else if (en) begin
      vld_q <= {vld_q[STAGES-1:0], in_valid && in_ready};
    end
  end

  // Input capture boundary: operands sign-extended to W+1 bits.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      ia_q <= {A[W-1], A};
      ib_q <= {B[W-1], B};
      im_q <= Cin;
    end
  end

  // Inter-stage boundaries: low sum bits, block carry, upper operands and mode.
  for (genvar j = 0; j < STAGES - 1; j++) begin : g_pipe
    always_ff @(posedge clk) begin
      if (en && vld_q[j]) begin
        pa_q[j] <= a_st[j];
        pb_q[j] <= b_st[j];
        pm_q[j] <= m_st[j];
        ps_q[j] <= sum_d[j];
        pc_q[j] <= cy_d[j];
      end
    end
  end

  // Output boundary: saturation (if built in) and overflow on the unsaturated sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      ovf_q <= 1'b0;
    end else if (en && vld_q[STAGES-1]) begin
      out_q <= sat_fn(sum_d[STAGES-1]);
      ovf_q <= ovf_fn(sum_d[STAGES-1]);
    end
  end
endmodule

// File: tb/tb_csa_addsub_pipe.sv
// Directed and random bench for csa_addsub_pipe (W=9/STAGES=2 directed, W=16/STAGES=3 random).
module tb_csa_addsub_pipe;
  localparam int W0 = 9;
  localparam int S0 = 2;
  localparam int W1 = 16;
  localparam int S1 = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                 d_in_valid, d_in_ready, d_cin, d_out_valid, d_out_ready, d_ovf;
  logic signed [W0-1:0] d_a, d_b;
  logic signed [W0:0]   d_out;

  logic                 r_in_valid, r_in_ready, r_cin, r_out_valid, r_out_ready, r_ovf;
  logic signed [W1-1:0] r_a, r_b;
  logic signed [W1:0]   r_out;

  int n_checks = 0;
  int n_errors = 0;

  csa_addsub_pipe #(.W(W0), .STAGES(S0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .A(d_a), .B(d_b), .Cin(d_cin), .out_valid(d_out_valid), .out_ready(d_out_ready),
    .Out(d_out), .ovf(d_ovf)
  );

  csa_addsub_pipe #(.W(W1), .STAGES(S1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(r_in_valid), .in_ready(r_in_ready),
    .A(r_a), .B(r_b), .Cin(r_cin), .out_valid(r_out_valid), .out_ready(r_out_ready),
    .Out(r_out), .ovf(r_ovf)
  );

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated beat on DUT0: checks latency of exactly S0 edges after the accept edge.
  task automatic run_one(input string tag, input int a, input int b, input logic c,
                         input int exp_out, input logic exp_ovf);
    d_a = W0'(a);
    d_b = W0'(b);
    d_cin = c;
    d_in_valid = 1'b1;
    step();
    d_in_valid = 1'b0;
    check_eq({tag, "_early0"}, d_out_valid, 0);
    step();
    check_eq({tag, "_early1"}, d_out_valid, 0);
    step();
    check_eq({tag, "_vld"}, d_out_valid, 1);
    check_eq({tag, "_out"}, d_out, exp_out);
    check_eq({tag, "_ovf"}, d_ovf, exp_ovf);
  endtask

  int bp_a [4] = '{10, 100, -100, 7};
  int bp_b [4] = '{20, -50, -100, -9};
  int bp_c [4] = '{0, 1, 0, 1};
  int bp_e [4] = '{30, 150, -200, 16};

  longint q_out [$];
  logic   q_ovf [$];

  initial begin
    int sent, rcv, stall, stall_cnt, nseen, acc, cyc;
    logic seen;
    logic signed [W0:0] held;
    logic signed [W1-1:0] ra, rb;
    logic rc;
    longint ex, e;
    logic eovf, eo;

    rst = 1'b1;
    d_in_valid = 1'b0; d_out_ready = 1'b1; d_a = '0; d_b = '0; d_cin = 1'b0;
    r_in_valid = 1'b0; r_out_ready = 1'b1; r_a = '0; r_b = '0; r_cin = 1'b0;
    held = '0;
    step();
    step();
    check_eq("rst_in_ready", d_in_ready, 0);
    check_eq("rst_out_valid", d_out_valid, 0);
    check_eq("rst_out", d_out, 0);
    check_eq("rst_ovf", d_ovf, 0);
    check_eq("rst_r_out_valid", r_out_valid, 0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_in_ready", d_in_ready, 1);

    run_one("add", 51, 29, 1'b0, 80, 1'b0);
    run_one("sub_negb", 100, -100, 1'b1, 200, 1'b0);

    // Two subtracts back-to-back must emerge on consecutive cycles.
    step();
    d_a = -9'sd26; d_b = 9'sd6; d_cin = 1'b1; d_in_valid = 1'b1;
    step();
    d_a = 9'sd37; d_b = 9'sd18; d_cin = 1'b1;
    step();
    d_in_valid = 1'b0;
    check_eq("b2b_early", d_out_valid, 0);
    step();
    check_eq("b2b_vld0", d_out_valid, 1);
    check_eq("b2b_out0", d_out, -32);
    step();
    check_eq("b2b_vld1", d_out_valid, 1);
    check_eq("b2b_out1", d_out, 19);
    step();
    check_eq("b2b_done", d_out_valid, 0);

`ifdef CSA_SAT_EN
    run_one("ovf_neg", -256, 255, 1'b1, -256, 1'b1);
    run_one("ovf_pos", 255, 255, 1'b0, 255, 1'b1);
`else
    run_one("ovf_neg", -256, 255, 1'b1, -511, 1'b1);
    run_one("ovf_pos", 255, 255, 1'b0, 510, 1'b1);
`endif
    run_one("edge_m128", -77, -51, 1'b0, -128, 1'b0);

    // Backpressure: 4 beats streamed, out_ready low for 3 cycles after the first out_valid.
    sent = 0; rcv = 0; stall = 0; stall_cnt = 0; seen = 1'b0;
    for (int cy = 0; cy < 30; cy++) begin
      @(posedge clk);
      #1;
      if (d_out_valid && !seen) begin
        seen = 1'b1;
        stall = 3;
      end
      d_out_ready = (stall > 0) ? 1'b0 : 1'b1;
      if (stall > 0) stall--;
      d_in_valid = (sent < 4);
      if (sent < 4) begin
        d_a = W0'(bp_a[sent]);
        d_b = W0'(bp_b[sent]);
        d_cin = (bp_c[sent] != 0);
      end
      #1;
      if (d_out_valid && !d_out_ready) begin
        if (stall_cnt == 0) held = d_out;
        else check_eq("bp_hold", d_out, held);
        check_eq("bp_in_ready", d_in_ready, 0);
        stall_cnt++;
      end
      if (d_in_valid && d_in_ready) sent++;
      if (d_out_valid && d_out_ready) begin
        if (rcv < 4) check_eq($sformatf("bp_out%0d", rcv), d_out, bp_e[rcv]);
        else check_eq("bp_extra", rcv, 3);
        rcv++;
      end
    end
    d_in_valid = 1'b0;
    d_out_ready = 1'b1;
    check_eq("bp_count", rcv, 4);
    check_eq("bp_stall_cycles", stall_cnt, 3);

    // Reset with two beats in flight.
    step();
    d_a = -9'sd256; d_b = 9'sd255; d_cin = 1'b1; d_in_valid = 1'b1;
    step();
    d_a = 9'sd51; d_b = 9'sd29; d_cin = 1'b0;
    step();
    d_in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_in_ready", d_in_ready, 0);
    step();
    check_eq("mid_rst_out_valid", d_out_valid, 0);
    check_eq("mid_rst_out", d_out, 0);
    check_eq("mid_rst_ovf", d_ovf, 0);
    rst = 1'b0;
    d_a = 9'sd12; d_b = -9'sd5; d_cin = 1'b0; d_in_valid = 1'b1;
    step();
    d_in_valid = 1'b0;
    nseen = 0;
    for (int i = 0; i < 8; i++) begin
      if (d_out_valid) begin
        nseen++;
        check_eq("mid_rst_new_out", d_out, 7);
      end
      step();
    end
    check_eq("mid_rst_new_count", nseen, 1);

    // Random regression on the W=16, STAGES=3 instance against an A+/-B model.
    acc = 0;
    cyc = 0;
    while ((acc < 1000 || q_out.size() > 0) && cyc < 20000) begin
      @(posedge clk);
      #1;
      cyc++;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 7) == 0) ra = $urandom_range(0, 1) ? 16'sh8000 : 16'sh7fff;
      if ($urandom_range(0, 7) == 0) rb = $urandom_range(0, 1) ? 16'sh8000 : 16'sh7fff;
      rc = 1'($urandom_range(0, 1));
      r_a = ra;
      r_b = rb;
      r_cin = rc;
      r_in_valid = (acc < 1000) && ($urandom_range(0, 3) != 0);
      r_out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (r_out_valid && r_out_ready) begin
        if (q_out.size() == 0) begin
          check_eq("rnd_spurious_beat", q_out.size(), 1);
        end else begin
          e = q_out.pop_front();
          eo = q_ovf.pop_front();
          check_eq("rnd_out", r_out, e);
          check_eq("rnd_ovf", r_ovf, eo);
        end
      end
      if (r_in_valid && r_in_ready) begin
        ex = rc ? (longint'(ra) - longint'(rb)) : (longint'(ra) + longint'(rb));
        eovf = (ex > 32767) || (ex < -32768);
`ifdef CSA_SAT_EN
        if (ex > 32767) ex = 32767;
        else if (ex < -32768) ex = -32768;
`endif
        q_out.push_back(ex);
        q_ovf.push_back(eovf);
        acc++;
      end
    end
    r_in_valid = 1'b0;
    check_eq("rnd_accepted", acc, 1000);
    check_eq("rnd_drained", q_out.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no summary expected completion");
    $fatal(1, "timeout");
  end
endmodule
